// File: rtl/draw_bridge.sv
// Drawbridge controller: car interlock, raise/lower sequencing,
// limit-switch fault detection and registered light/motor/alarm.
module draw_bridge (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CAIN,
  input  logic       CAO,
  input  logic       MD,
  input  logic       PB,
  input  logic       BS,
  input  logic       H,
  input  logic       L,
  output logic       MT,
  output logic       AL,
  output logic       TFL,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    FLAT     = 2'd0,
    LIFTING  = 2'd1,
    UPRIGHT  = 2'd2,
    LOWERING = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mt_q, mt_d;
  logic       al_q, al_d;
  logic       tfl_q, tfl_d;

  logic raise, lower, fault;

  assign raise = MD ? PB : BS;
  assign lower = MD ? PB : ~BS;
  assign fault = (H & L) | (H & (state_q == LOWERING));

  // Car counter: saturating up/down, simultaneous in/out cancels
  always_comb begin
    cnt_d = cnt_q;
    if (CAIN && !CAO && cnt_q != 4'hF)
      cnt_d = cnt_q + 4'd1;
    else if (CAO && !CAIN && cnt_q != 4'h0)
      cnt_d = cnt_q - 4'd1;
  end

  // Next state and registered outputs derived from it
  always_comb begin
    state_d = state_q;
    if (!fault) begin
      unique case (state_q)
        FLAT:
          if (raise && cnt_q == 4'd0) state_d = LIFTING;
        LIFTING:
          if (H) state_d = UPRIGHT;
        UPRIGHT:
          if (lower) state_d = LOWERING;
        LOWERING:
          if (L) state_d = FLAT;
        default: state_d = FLAT;
      endcase
    end
    mt_d  = ~fault &
            ((state_d == LIFTING) | (state_d == LOWERING));
    al_d  = fault;
    tfl_d = (state_d != FLAT) | raise;
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= FLAT;
      cnt_q   <= 4'd0;
      mt_q    <= 1'b0;
      al_q    <= 1'b0;
      tfl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mt_q    <= mt_d;
      al_q    <= al_d;
      tfl_q   <= tfl_d;
    end
  end

  assign MT    = mt_q;
  assign AL    = al_q;
  assign TFL   = tfl_q;
  assign State = state_q;

endmodule

// File: tb/tb_draw_bridge.sv
// Self-checking bench for draw_bridge: behavioural model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_draw_bridge;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       CAIN = 1'b0, CAO = 1'b0, MD = 1'b0, PB = 1'b0;
  logic       BS = 1'b0, H = 1'b0, L = 1'b0;
  logic       MT, AL, TFL;
  logic [1:0] State;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int m_st = 0;
  int m_cnt = 0;
  bit m_mt = 0, m_al = 0, m_tfl = 0;
  bit m_valid = 0;

  draw_bridge dut (
    .Clk(Clk), .Reset(Reset), .CAIN(CAIN), .CAO(CAO),
    .MD(MD), .PB(PB), .BS(BS), .H(H), .L(L),
    .MT(MT), .AL(AL), .TFL(TFL), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model from the rules: one call per rising edge
  task automatic model_step();
    bit rq, lq, flt;
    int ns;
    if (!Reset) begin
      m_st = 0; m_cnt = 0;
      m_mt = 0; m_al = 0; m_tfl = 0;
      m_valid = 1;
      return;
    end
    rq  = MD ? PB : BS;
    lq  = MD ? PB : !BS;
    flt = (H && L) || (H && m_st == 3);
    ns  = m_st;
    if (!flt) begin
      if (m_st == 0 && rq && m_cnt == 0) ns = 1;
      else if (m_st == 1 && H) ns = 2;
      else if (m_st == 2 && lq) ns = 3;
      else if (m_st == 3 && L) ns = 0;
    end
    if (CAIN && !CAO) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
    if (CAO && !CAIN) m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
    m_mt  = !flt && (ns == 1 || ns == 3);
    m_al  = flt;
    m_tfl = (ns != 0) || rq;
    m_st  = ns;
  endtask

  // Compare process: model advances on the edge, outputs checked 1ns later
  always @(posedge Clk) begin
    model_step();
    #1;
    if (m_valid) begin
      chk("cmp_State", int'(State), m_st);
      chk("cmp_MT", int'(MT), int'(m_mt));
      chk("cmp_AL", int'(AL), int'(m_al));
      chk("cmp_TFL", int'(TFL), int'(m_tfl));
    end
  end

  task automatic step(input bit rst, input bit cain, input bit cao,
                      input bit md, input bit pb, input bit bs,
                      input bit h, input bit l);
    @(negedge Clk);
    Reset = rst; CAIN = cain; CAO = cao; MD = md;
    PB = pb; BS = bs; H = h; L = l;
    @(posedge Clk);
    #2;
  endtask

  initial begin
    // reset
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 1);
    chk("rst_State", int'(State), 0);
    chk("rst_MT", int'(MT), 0);
    chk("rst_AL", int'(AL), 0);
    chk("rst_TFL", int'(TFL), 0);
    chk("rst_cnt", m_cnt, 0);

    // automatic cycle
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("auto1_cnt", m_cnt, 1);
    chk("auto1_State", int'(State), 0);
    step(1, 0, 1, 0, 0, 1, 0, 0);
    chk("auto2_cnt", m_cnt, 0);
    chk("auto2_State", int'(State), 0);
    chk("auto2_TFL", int'(TFL), 1);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    chk("auto3_State", int'(State), 1);
    chk("auto3_MT", int'(MT), 1);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    chk("auto4_State", int'(State), 2);
    chk("auto4_MT", int'(MT), 0);
    chk("auto4_TFL", int'(TFL), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("auto5_State", int'(State), 3);
    chk("auto5_MT", int'(MT), 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("auto6_State", int'(State), 0);
    chk("auto6_MT", int'(MT), 0);
    chk("auto6_TFL", int'(TFL), 0);

    // car interlock
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("lock_cnt", m_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 1, 0, 0);
      chk("lock_State", int'(State), 0);
      chk("lock_TFL", int'(TFL), 1);
    end
    step(1, 0, 1, 0, 0, 1, 0, 0);
    chk("lock_cao_State", int'(State), 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    chk("lock_lift_State", int'(State), 1);

    // fault in LOWERING
    step(1, 0, 0, 0, 0, 1, 1, 0);
    chk("fl_up_State", int'(State), 2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("fl_low_State", int'(State), 3);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("fl_AL", int'(AL), 1);
    chk("fl_MT", int'(MT), 0);
    chk("fl_State", int'(State), 3);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("fl_clr_AL", int'(AL), 0);
    chk("fl_clr_State", int'(State), 0);

    // manual mode
    step(1, 0, 0, 1, 0, 1, 0, 0);
    chk("man_nolift", int'(State), 0);
    step(1, 0, 0, 1, 1, 1, 0, 0);
    chk("man_lift", int'(State), 1);
    step(1, 0, 0, 1, 0, 1, 1, 0);
    chk("man_up", int'(State), 2);
    step(1, 0, 0, 1, 1, 1, 0, 0);
    chk("man_lower", int'(State), 3);
    step(1, 0, 0, 1, 0, 0, 0, 1);
    chk("man_flat", int'(State), 0);

    // reset mid-lift, then H/L fault in FLAT
    step(1, 0, 0, 0, 0, 1, 0, 0);
    chk("rl_lift", int'(State), 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("rl_State", int'(State), 0);
    chk("rl_MT", int'(MT), 0);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    chk("hl_AL", int'(AL), 1);
    chk("hl_State", int'(State), 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);

    // counter saturation at 15
    for (int i = 0; i < 18; i++)
      step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("sat_hi", m_cnt, 15);
    for (int i = 0; i < 17; i++)
      step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("sat_lo", m_cnt, 0);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end

    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_bridge.md
DRAW_BRIDGE -- requirements
Module: draw_bridge

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset named Reset; Clk rising edge is the only sampling edge.
REQ-002 The ports SHALL be (name  direction  width  meaning):
- Clk  in  1  clock
- Reset  in  1  synchronous active-low reset
- CAIN  in  1  car-entering sensor, one car per high cycle
- CAO  in  1  car-leaving sensor, one car per high cycle
- MD  in  1  mode: 0 automatic, 1 manual
- PB  in  1  operator push button, used in manual mode only
- BS  in  1  boat-present sensor
- H  in  1  bridge fully-up limit switch
- L  in  1  bridge fully-down limit switch
- MT  out  1  motor enable
- AL  out  1  alarm
- TFL  out  1  traffic light: 1 = stop/red, 0 = go
- State  out  2  current state code
REQ-003 All outputs SHALL be registered and SHALL change only on a Clk rising edge.

Function
REQ-004 State encoding SHALL be FLAT=0, LIFTING=1, UPRIGHT=2, LOWERING=3, and State SHALL equal the state register.
REQ-005 A 4-bit car counter SHALL track cars on the deck.
- CAIN only: +1, saturating at 15.
- CAO only: -1, saturating at 0.
- Both or neither high: unchanged.
- The counter SHALL update in every state.
REQ-006 The raise request SHALL be BS when MD=0 and PB when MD=1.
REQ-007 The lower request SHALL be !BS when MD=0 and PB when MD=1.
REQ-008 A fault SHALL exist in a cycle when H=1 and L=1 in any state, or when H=1 while in LOWERING.
REQ-009 During a fault, the state SHALL hold.
REQ-010 When there is no fault, state transitions SHALL be:
- FLAT -> LIFTING when the raise request is high and the registered car count equals 0. The count value is the one before this edge, so a car leaving in the same cycle does not count until the next cycle.
- LIFTING -> UPRIGHT when H=1.
- UPRIGHT -> LOWERING when the lower request is high.
- LOWERING -> FLAT when L=1.
- Otherwise the state holds.
REQ-011 MT SHALL register 1 exactly when the next state is LIFTING or LOWERING and there is no fault; otherwise 0.
REQ-012 AL SHALL register 1 in every cycle a fault exists and 0 otherwise; it is non-latching.
REQ-013 TFL SHALL register 1 when the next state is not FLAT, or when the next state is FLAT and the raise request is high; otherwise 0.
REQ-014 A change of MD SHALL take effect on the next edge and SHALL not alter the state.
REQ-015 PB and BS SHALL be level-sensitive with no edge detection.

Reset
REQ-016 On a rising edge with Reset=0, the block SHALL set State=FLAT, counter=0, MT=0, AL=0 and TFL=0, ignoring all other inputs.
REQ-017 Reset SHALL take priority at any point in a sequence, including mid-lift or mid-lower.
REQ-018 The first edge with Reset=1 SHALL apply normal operation.

Verification
REQ-019 The bench SHALL cover the automatic cycle, run on successive edges:
- CAIN=1 -> count 1, State 0.
- CAO=1, BS=1 -> count 0, State 0, TFL=1.
- BS=1, L=0 -> State 1, MT=1.
- H=1 -> State 2, MT=0, TFL=1.
- BS=0 -> State 3, MT=1.
- L=1 -> State 0, MT=0, TFL=0.
REQ-020 The bench SHALL cover the car interlock: count 1 with BS=1 held for 3 edges -> State stays 0 and TFL=1. After CAO=1 for one edge -> State 1 on the following edge.
REQ-021 The bench SHALL cover the fault in LOWERING: in LOWERING apply H=1 -> AL=1, MT=0, State stays 3. Then H=0, L=1 -> AL=0, State 0.
REQ-022 The bench SHALL cover manual mode:
- MD=1, BS=1, PB=0 in FLAT -> no lift.
- PB=1 -> State 1.
- In UPRIGHT with BS=1 and PB=1 -> State 3.
REQ-023 The bench SHALL cover reset and the H/L fault:
- Reset=0 in LIFTING -> State 0, MT=0 after one edge.
- H=1, L=1 in FLAT -> AL=1, State 0.
